// File: rtl/disc_sqrt.sv
// rtl/disc_sqrt.sv - discriminant b*b-4c and radix-4 restoring integer square root of |D|
// Optional build macro: DISC_SQRT_ROUND_EN (round root to nearest instead of floor).
module disc_sqrt (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [7:0]  b,
    input  logic signed [7:0]  c,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [15:0] disc,
    output logic [7:0]         root,
    output logic               neg,
    output logic               exact
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DISC = 2'd1;
    localparam logic [1:0] SQRT = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]         state;
    logic signed [7:0]  b_r;
    logic signed [7:0]  c_r;
    logic signed [15:0] d_r;
    logic [15:0]        rad;
    logic [11:0]        rem;
    logic [7:0]         proot;
    logic [2:0]         cnt;
    logic               fin;

    logic signed [15:0] bx;
    logic signed [15:0] cx;
    logic signed [15:0] d_calc;
    logic [15:0]        d_abs;
    logic [13:0]        rem_sh;
    logic [13:0]        trial;
    logic [13:0]        rem_sub;
    logic               ge;
    logic [7:0]         root_fin;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_comb begin
        bx      = {{8{b_r[7]}}, b_r};
        cx      = {{8{c_r[7]}}, c_r};
        d_calc  = bx * bx - cx * 16'sd4;
        d_abs   = d_calc[15] ? 16'(-d_calc) : 16'(d_calc);
        rem_sh  = {rem, rad[15:14]};
        trial   = {4'b0000, proot, 2'b01};
        ge      = (rem_sh >= trial);
        rem_sub = rem_sh - trial;
`ifdef DISC_SQRT_ROUND_EN
        root_fin = proot + {7'd0, (rem > {4'b0000, proot})};
`else
        root_fin = proot;
`endif
    end

    // The cycle after the last iteration (fin set) registers the results on entry to DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            b_r   <= '0;
            c_r   <= '0;
            d_r   <= '0;
            rad   <= '0;
            rem   <= '0;
            proot <= '0;
            cnt   <= '0;
            fin   <= 1'b0;
            disc  <= '0;
            root  <= '0;
            neg   <= 1'b0;
            exact <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        b_r   <= b;
                        c_r   <= c;
                        state <= DISC;
                    end
                end
                DISC: begin
                    d_r   <= d_calc;
                    rad   <= d_abs;
                    rem   <= '0;
                    proot <= '0;
                    cnt   <= 3'd7;
                    fin   <= 1'b0;
                    state <= SQRT;
                end
                SQRT: begin
                    if (fin) begin
                        disc  <= d_r;
                        root  <= root_fin;
                        neg   <= d_r[15];
                        exact <= (rem == 12'd0);
                        state <= DONE;
                    end else begin
                        rem   <= ge ? rem_sub[11:0] : rem_sh[11:0];
                        proot <= {proot[6:0], ge};
                        rad   <= {rad[13:0], 2'b00};
                        cnt   <= cnt - 3'd1;
                        if (cnt == 3'd0) begin
                            fin <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_disc_sqrt.sv
// tb/tb_disc_sqrt.sv - scoreboard bench for disc_sqrt against an arithmetic reference model
module tb_disc_sqrt;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               out_ready = 1'b1;
    logic signed [7:0]  b = '0;
    logic signed [7:0]  c = '0;
    logic               in_ready;
    logic               out_valid;
    logic signed [15:0] disc;
    logic [7:0]         root;
    logic               neg;
    logic               exact;

    disc_sqrt dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .b         (b),
        .c         (c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .disc      (disc),
        .root      (root),
        .neg       (neg),
        .exact     (exact)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    bit rand_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int d;
        int r;
        int n;
        int e;
    } exp_t;

    exp_t sbq[$];

    function automatic exp_t model(input int bi, input int ci);
        exp_t x;
        int a;
        int r;
        int rm;
        x.d = bi * bi - 4 * ci;
        a = (x.d < 0) ? -x.d : x.d;
        r = 0;
        while ((r + 1) * (r + 1) <= a) r++;
        rm = a - r * r;
        x.e = (rm == 0) ? 1 : 0;
        x.n = (x.d < 0) ? 1 : 0;
`ifdef DISC_SQRT_ROUND_EN
        if (rm > r) r++;
`endif
        x.r = r;
        return x;
    endfunction

    task automatic check(input string name, input int act, input int expv);
        compared++;
        if (act != expv) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: a result is consumed at the edge following a negedge with valid and ready both high.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("disc", int'(disc), e.d);
                check("root", int'(root), e.r);
                check("neg", int'(neg), e.n);
                check("exact", int'(exact), e.e);
            end
        end
    end

    task automatic send(input int bi, input int ci, input bit push, output int acc);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        b = 8'(bi);
        c = 8'(ci);
        in_valid = 1'b1;
        if (push) sbq.push_back(model(bi, ci));
        @(posedge clk);
        #1;
        acc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check("drain_timeout", sbq.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out_valid();
        int n;
        n = 0;
        while (!out_valid && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("out_valid_timeout", int'(out_valid), 1);
    endtask

    initial begin
        int acc;
        int d0;
        int r0;
        int n0;
        int e0;
        bit seen;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_disc", int'(disc), 0);
        check("rst_root", int'(root), 0);
        check("rst_neg", int'(neg), 0);
        check("rst_exact", int'(exact), 0);

        // Latency from accept edge to out_valid
        out_ready = 1'b1;
        send(-2, 5, 1'b1, acc);
        wait_out_valid();
        check("latency", cyc - acc, 10);
        drain();

        send(3, -4, 1'b1, acc);
        send(0, 0, 1'b1, acc);
        send(-128, -128, 1'b1, acc);
        send(1, 1, 1'b1, acc);
        drain();

        // Backpressure: DONE holds with stable outputs
        out_ready = 1'b0;
        send(7, 3, 1'b1, acc);
        wait_out_valid();
        d0 = int'(disc);
        r0 = int'(root);
        n0 = int'(neg);
        e0 = int'(exact);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_disc", int'(disc), d0);
            check("bp_root", int'(root), r0);
            check("bp_neg", int'(neg), n0);
            check("bp_exact", int'(exact), e0);
        end
        out_ready = 1'b1;
        drain();

        // Busy: second request held from SQRT is only taken after DONE -> IDLE
        send(5, 2, 1'b1, acc);
        repeat (3) @(posedge clk);
        #1;
        b = 8'sd9;
        c = 8'sd9;
        in_valid = 1'b1;
        for (int i = 4; i <= 10; i++) begin
            @(posedge clk);
            #1;
            check("busy_in_ready", int'(in_ready), 0);
        end
        @(posedge clk);
        #1;
        check("busy_idle_in_ready", int'(in_ready), 1);
        sbq.push_back(model(9, 9));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("busy_accepted", int'(in_ready), 0);
        drain();

        // Reset during SQRT aborts the transaction
        send(3, -4, 1'b0, acc);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_in_ready", int'(in_ready), 1);
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_disc", int'(disc), 0);
        check("mid_rst_root", int'(root), 0);
        check("mid_rst_neg", int'(neg), 0);
        check("mid_rst_exact", int'(exact), 0);
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("mid_rst_no_pulse", int'(seen), 0);
        send(3, -4, 1'b1, acc);
        drain();

        // Randomized traffic with random backpressure
        rand_ready = 1'b1;
        fork
            begin
                while (rand_ready) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join_none
        for (int i = 0; i < 40; i++) begin
            send(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128, 1'b1, acc);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        rand_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
